// File: rtl/detector_rr_scheduler_pkg.sv
// Shared types for the round-robin detector scheduler: FSM encodings and default sizes.
package detector_rr_scheduler_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_FRAME_LEN = 8;
  localparam int DEF_CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } sched_state_t;

  typedef enum logic [1:0] {
    START  = 2'b00,
    MIDWAY = 2'b01,
    DONES  = 2'b10
  } det_state_t;

endpackage

// File: rtl/detector_rr_scheduler_if.sv
// Requester-side bus of the scheduler: request/data inputs and grant/report outputs.
interface detector_rr_scheduler_if
  import detector_rr_scheduler_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int CNT_W = DEF_CNT_W
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] din_bus;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic             hit;
  logic             done;
  logic             aborted;
  logic [ID_W-1:0]  done_id;
  logic [CNT_W-1:0] hit_count;

  modport master (
    output req, din_bus,
    input  grant, busy, hit, done, aborted, done_id, hit_count
  );

  modport slave (
    input  req, din_bus,
    output grant, busy, hit, done, aborted, done_id, hit_count
  );

endinterface

// File: rtl/detector_rr_scheduler_seq_detect_sync.sv
// Serial 1-x-1 Mealy detector with synchronous reset, synchronous clear and enable.
module seq_detect_sync
  import detector_rr_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic hit
);

  det_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (clr) begin
      state_d = START;
    end else if (en) begin
      case (state_q)
        START:   if (din) state_d = MIDWAY;
        MIDWAY:  state_d = DONES;
        DONES:   state_d = START;
        default: state_d = START;
      endcase
      hit = (state_q == DONES) && din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= START;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/detector_rr_scheduler.sv
// Round-robin scheduler sharing one 1-x-1 detector among serial requesters.
// Each grant is a fixed-length, non-preemptive frame; Done reports the ID and hit count.
module detector_rr_scheduler
  import detector_rr_scheduler_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  detector_rr_scheduler_if.slave bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int BIT_W = $clog2(FRAME_LEN);

  sched_state_t     state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  done_id_q, done_id_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             aborted_q, aborted_d;

  logic [ID_W-1:0]  winner;
  int               idx;
  logic             det_clr;
  logic             det_en;
  logic             det_din;
  logic             det_hit;
  logic             abort;

  // First requesting bit strictly after the last grant, wrapping around.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(last_q) + i) % N_REQ;
      if (bus.req[ID_W'(idx)]) winner = ID_W'(idx);
    end
  end

  assign det_clr = (state_q == IDLE) && (|bus.req);
  assign abort   = (state_q == RUN) && !bus.req[gnt_id_q];
  assign det_en  = (state_q == RUN) && bus.req[gnt_id_q];
  assign det_din = bus.din_bus[gnt_id_q];

  seq_detect_sync u_det (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .en  (det_en),
    .din (det_din),
    .hit (det_hit)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gnt_id_d  = gnt_id_q;
    last_d    = last_q;
    done_id_d = done_id_q;
    bit_cnt_d = bit_cnt_q;
    hit_cnt_d = hit_cnt_q;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d   = RUN;
          grant_d   = N_REQ'(1) << winner;
          gnt_id_d  = winner;
          bit_cnt_d = '0;
          hit_cnt_d = '0;
          aborted_d = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = DONE;
          grant_d   = '0;
          done_id_d = gnt_id_q;
          last_d    = gnt_id_q;
          aborted_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (det_hit && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end
          if (bit_cnt_q == BIT_W'(FRAME_LEN - 1)) begin
            state_d   = DONE;
            grant_d   = '0;
            done_id_d = gnt_id_q;
            last_d    = gnt_id_q;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        aborted_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to the top index so requester 0 wins the first search.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gnt_id_q  <= '0;
      last_q    <= ID_W'(N_REQ - 1);
      done_id_q <= '0;
      bit_cnt_q <= '0;
      hit_cnt_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gnt_id_q  <= gnt_id_d;
      last_q    <= last_d;
      done_id_q <= done_id_d;
      bit_cnt_q <= bit_cnt_d;
      hit_cnt_q <= hit_cnt_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.hit       = det_hit;
  assign bus.done      = (state_q == DONE);
  assign bus.aborted   = aborted_q;
  assign bus.done_id   = done_id_q;
  assign bus.hit_count = hit_cnt_q;

endmodule

// File: tb/tb_detector_rr_scheduler.sv
// Scoreboard bench: frame-level reference model feeds expected reports; a monitor checks each Done.
module tb_detector_rr_scheduler;

  localparam int N = 4;
  localparam int F = 8;

  typedef struct {
    int id;
    int ab;
    int hits;
  } exp_t;

  logic clk;
  logic rst;
  logic [N-1:0] req;
  logic [N-1:0] din_bus;

  int tests;
  int fails;
  int model_last;
  exp_t exp_q[$];
  exp_t sat_q[$];

  detector_rr_scheduler_if #(.N_REQ(N), .CNT_W(4)) bus ();
  detector_rr_scheduler_if #(.N_REQ(N), .CNT_W(1)) sbus ();

  assign bus.req      = req;
  assign bus.din_bus  = din_bus;
  assign sbus.req     = req;
  assign sbus.din_bus = din_bus;

  detector_rr_scheduler #(.N_REQ(N), .FRAME_LEN(F), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  detector_rr_scheduler #(.N_REQ(N), .FRAME_LEN(F), .CNT_W(1)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int i = 1; i <= N; i++) begin
      if (r[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  // A 1 opens a three-bit window; its third bit being 1 is a hit, and scanning resumes after it.
  function automatic logic [F-1:0] hit_mask(input logic [F-1:0] bits, input int nproc);
    logic [F-1:0] m;
    int pos;
    m   = '0;
    pos = 0;
    while (pos < nproc) begin
      if (bits[pos]) begin
        if ((pos + 2 < nproc) && bits[pos + 2]) m[pos + 2] = 1'b1;
        pos += 3;
      end else begin
        pos += 1;
      end
    end
    return m;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_grant"}, int'(bus.grant), 0);
    checkOutput({tag, "_busy"}, int'(bus.busy), 0);
    checkOutput({tag, "_done"}, int'(bus.done), 0);
    checkOutput({tag, "_aborted"}, int'(bus.aborted), 0);
    checkOutput({tag, "_done_id"}, int'(bus.done_id), 0);
    checkOutput({tag, "_hit_count"}, int'(bus.hit_count), 0);
  endtask

  // Called in an IDLE cycle, #1 after an edge; returns in the following IDLE cycle.
  task automatic applyStimulus(input logic [N-1:0] pattern, input logic [F-1:0] bits,
                               input int abort_at, input int reset_at);
    int w;
    int nproc;
    logic [F-1:0] hm;
    exp_t e;
    w       = rr_pick(pattern, model_last);
    req     = pattern;
    din_bus = N'($urandom);
    @(posedge clk); #1;
    if (w < 0) return;
    nproc = (abort_at >= 0) ? abort_at : F;
    hm    = hit_mask(bits, nproc);
    for (int j = 0; j < F; j++) begin
      din_bus    = N'($urandom);
      din_bus[w] = bits[j];
      req        = N'($urandom);
      req[w]     = (j != abort_at);
      if (j == reset_at) rst = 1'b1;
      #1;
      checkOutput("run_grant", int'(bus.grant), 1 << w);
      checkOutput("run_busy", int'(bus.busy), 1);
      checkOutput("run_hit", int'(bus.hit), int'(hm[j]));
      @(posedge clk); #1;
      if (j == reset_at) begin
        checkResetValues("midrun_reset");
        @(posedge clk); #1;
        checkOutput("reset_hold_done", int'(bus.done), 0);
        rst        = 1'b0;
        model_last = N - 1;
        return;
      end
      if (j == abort_at) break;
    end
    e.id   = w;
    e.ab   = (abort_at >= 0) ? 1 : 0;
    e.hits = $countones(hm);
    exp_q.push_back(e);
    sat_q.push_back(e);
    model_last = w;
    req = N'($urandom);
    checkOutput("done_grant", int'(bus.grant), 0);
    checkOutput("done_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: every Done pulse consumes one expected frame report per DUT.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("done_id", int'(bus.done_id), e.id);
        checkOutput("aborted", int'(bus.aborted), e.ab);
        checkOutput("hit_count", int'(bus.hit_count), (e.hits > 15) ? 15 : e.hits);
      end
    end
    if (sbus.done === 1'b1) begin
      if (sat_q.size() == 0) begin
        checkOutput("sat_unexpected_done", 1, 0);
      end else begin
        e = sat_q.pop_front();
        checkOutput("sat_done_id", int'(sbus.done_id), e.id);
        checkOutput("sat_hit_count", int'(sbus.hit_count), (e.hits > 1) ? 1 : e.hits);
      end
    end
  end

  initial begin
    logic [N-1:0] pat;
    logic [F-1:0] bits;
    int ab;
    tests      = 0;
    fails      = 0;
    model_last = N - 1;
    rst        = 1'b1;
    req        = '1;
    din_bus    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;

    applyStimulus(4'b1111, 8'($urandom), -1, -1);
    applyStimulus(4'b0100, 8'b0000_0101, -1, -1);
    applyStimulus(4'b0001, 8'b1111_1111, -1, -1);
    for (int n = 0; n < 5; n++) applyStimulus(4'b1111, 8'($urandom), -1, -1);
    applyStimulus(4'b0010, 8'b1111_1111, 3, -1);
    applyStimulus(4'b1100, 8'($urandom), -1, -1);
    applyStimulus(4'b1001, 8'b1111_1111, -1, 4);
    applyStimulus(4'b1001, 8'($urandom), -1, -1);

    for (int n = 0; n < 40; n++) begin
      pat  = N'($urandom_range(0, 15));
      bits = F'($urandom);
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, F - 1)) : -1;
      applyStimulus(pat, bits, ab, -1);
    end

    req = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pending_reports", exp_q.size(), 0);
    checkOutput("sat_pending_reports", sat_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/detector_rr_scheduler.md
Name: detector_rr_scheduler

Overview:
- Shares one serial "1-x-1" Mealy pattern detector among N_REQ serial requesters using round-robin arbitration.
- Each grant is a non-preemptive frame of FRAME_LEN bits. During the frame the detector watches the granted requester's bit stream and the block counts detections.
- At the end of the frame the block reports the requester ID and the hit count.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- FRAME_LEN, 8, bits per grant window (>=3)
- CNT_W, 4, width of the hit counter

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high; sampled on the rising edge of Clock
- Req  in  N_REQ  per-requester request level
- Din_bus  in  N_REQ  per-requester serial data bit
- Grant  out  N_REQ  one-hot grant, registered
- Busy  out  1  high while in RUN
- Hit  out  1  Mealy detector output, gated by RUN (combinational)
- Done  out  1  one-cycle pulse, end of frame
- Aborted  out  1  valid with Done: frame ended early
- Done_id  out  clog2(N_REQ)  ID of the finished requester; held until the next Done
- Hit_count  out  CNT_W  hits in the last or current frame; held after Done

Behaviour:
- Reset (synchronous, takes effect at the edge): FSM to IDLE. Grant=0, Busy=0, Done=0, Aborted=0, Done_id=0, Hit_count=0, bit counter=0. RR pointer reset so requester 0 has highest priority. Detector to its Start state.
- Scheduler FSM states: IDLE, RUN, DONE.
- IDLE:
  - Req is sampled every cycle.
  - If any bit is set, pick the first set bit searching upward from (last_grant+1) mod N_REQ, with wrap.
  - On that edge: Grant = one-hot(winner), Busy=1, bit counter=0, Hit_count=0, detector cleared to Start, state goes to RUN.
  - If Req=0, remain in IDLE.
- RUN:
  - Detector input = Din_bus[granted].
  - Detector transitions: Start goes to Midway on 1, else stays in Start. Midway always goes to DoneS. DoneS always goes to Start.
  - Hit = (state==DoneS && din==1) && RUN.
  - On each edge with Hit=1: Hit_count += 1, saturating at 2^CNT_W-1.
  - Bit counter increments every edge.
  - On the edge where bit counter == FRAME_LEN-1: go to DONE.
  - Abort: if Req[granted]==0 during RUN, go to DONE at that edge with Aborted=1. The current bit is not counted, and Hit is forced to 0 in that cycle.
- DONE (exactly 1 cycle):
  - Done=1, Done_id=granted ID; Aborted as set.
  - Grant=0, Busy=0 from this cycle on.
  - last_grant updated.
  - Next state is IDLE.
- Latency and throughput:
  - Req seen at edge k: Grant visible cycle k+1 through k+FRAME_LEN; Done in cycle k+FRAME_LEN+1.
  - Earliest next Grant is cycle k+FRAME_LEN+3, giving a frame period of FRAME_LEN+2.
- Detector state is never carried across frames: it is cleared on every grant.
- Requests that arrive or change during RUN or DONE are ignored until IDLE. No preemption.
- Reset mid-RUN: the frame is dropped. No Done pulse and no Aborted are produced, and all outputs take their reset values at the edge.
- Grant is always one-hot or zero. Never more than one bit is set.

Decomposition:
- Shared package:
  - sched_state_t encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - det_state_t encodings: Start=2'b00, Midway=2'b01, DoneS=2'b10.
- Sub-module seq_detect_sync holds the detector. It has the same 1-x-1 Mealy behaviour plus:
  - synchronous active-high Reset;
  - a synchronous clear input (Clr);
  - an enable input (En).
- The scheduler (RR pick, bit counter, saturating counter, FSM) stays in the top module.

Test Plan:
1. Reset=1 for 2 cycles with Req=4'b1111 -> Grant=0, Busy=0, Done=0, Hit_count=0. After release, the first Grant is 4'b0001.
2. Req=4'b0100 only; Din_bus[2] bits = 1,0,1,0,0,0,0,0 -> Grant=4'b0100 for 8 cycles, Hit pulses on bit index 2. Then Done=1, Done_id=2, Aborted=0, Hit_count=1.
3. Req=4'b0001, Din_bus[0]=1 for all 8 bits -> Hit at bit indices 2 and 5 (none at 7), Hit_count=2. With CNT_W=1 the same stimulus gives Hit_count=1 (saturated).
4. Req=4'b1111 held -> grant order 0,1,2,3,0 with Grant rising edges exactly 10 cycles apart; four Done pulses with Done_id 0,1,2,3.
5. Requester 1 granted, Req[1] dropped at bit index 3 -> DONE at that edge, Done=1, Aborted=1, Done_id=1. With Req=4'b1100 pending, the next grant goes to 2.
6. Reset asserted at bit 4 of requester 3's frame, with Req=4'b1001 held -> no Done pulse, outputs at reset values; after release, Grant=4'b0001 (pointer reset).
